tlb_lookup_unit: RTL and testbench

//  Translation responder behind the MMU address-translation stage. Holds a fully-associative
//  LA32 TLB and answers lookup requests with a registered PFN/MAT/PLV/D/V result. The PFN is

---
 rtl/tlb_pkg.sv | 46 ++++
 rtl/tlb_match.sv | 43 ++++
 rtl/tlb_lookup_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_tlb_lookup_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the LA32 TLB lookup unit.
//   page_t       one half of a TLB entry (even/odd page)
//   tlb_entry_t  full TLB entry as written by TLBWR/TLBFILL and read by TLBRD
//   invtlb_op_e  INVTLB operation codes (0..6 are valid)
//   sweep_state_e  INVTLB sweep controller states
package tlb_pkg;

    // ps4m value that selects a 4MB page; the other value selects 4KB
    localparam logic TLB_PS4M = 1'b1;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } page_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic        ps4m;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        page_t       p0;
        page_t       p1;
    } tlb_entry_t;

    typedef enum logic [4:0] {
        INV_ALL        = 5'd0,
        INV_ALL_1      = 5'd1,
        INV_GLOBAL     = 5'd2,
        INV_NONGLOBAL  = 5'd3,
        INV_NG_ASID    = 5'd4,
        INV_NG_ASID_VA = 5'd5,
        INV_ASID_VA    = 5'd6
    } invtlb_op_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } sweep_state_e;

endpackage

// File: rtl/tlb_match.sv
// tlb_match: compares one TLB entry against a virtual page number and ASID.
//   entry    in   tlb_entry_t  entry under test
//   vpn      in   20           va[31:12]
//   asid     in   10           ASID to compare
//   use_g    in   1            1: a global entry matches any ASID; 0: ASID must match
//   hit      out  1            E & (G-override | asid_eq) & va_eq
//   va_eq    out  1            VPPN compare at the entry's page size
//   asid_eq  out  1            entry ASID equals asid
//   odd      out  1            odd page of the pair selected
//   page     out  page_t       selected page with PFN merged for page size
module tlb_match
    import tlb_pkg::*;
(
    input  tlb_entry_t  entry,
    input  logic [19:0] vpn,
    input  logic [9:0]  asid,
    input  logic        use_g,
    output logic        hit,
    output logic        va_eq,
    output logic        asid_eq,
    output logic        odd,
    output page_t       page
);

    always_comb begin
        asid_eq = (entry.asid == asid);
        if (entry.ps4m == TLB_PS4M) begin
            va_eq = (entry.vppn[18:9] == vpn[19:10]);
            odd   = vpn[9];
        end else begin
            va_eq = (entry.vppn == vpn[19:1]);
            odd   = vpn[0];
        end
        hit  = entry.e & ((use_g & entry.g) | asid_eq) & va_eq;
        page = odd ? entry.p1 : entry.p0;
        // 4MB page: low PFN bits come from the VA so the translator can
        // always form {pfn, va[11:0]}
        if (entry.ps4m == TLB_PS4M) begin
            page.ppn = {page.ppn[19:10], vpn[9:0]};
        end
    end

endmodule

// File: rtl/tlb_lookup_unit.sv
// tlb_lookup_unit: fully-associative LA32 TLB with registered lookup port,
// TLBWR/TLBFILL write port, TLBRD read port and a multi-cycle INVTLB sweep.
//   clk, resetn                    clock, async active-low reset
//   req_valid/req_ready/req_vaddr/req_asid   lookup request
//   rsp_valid/hit/multi/idx/pfn/mat/plv/d/v  lookup result, 1 cycle after accept
//   w_en/w_idx/w_entry             entry write (ignored while busy)
//   r_idx/r_entry                  TLBRD, registered, 1-cycle latency
//   fill_idx                       free-running pseudo-random TLBFILL index
//   inv_valid/inv_op/inv_asid/inv_va   INVTLB start and operands
//   busy/inv_done                  sweep in progress / final-cycle pulse
module tlb_lookup_unit
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16
)
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_vaddr,
    input  logic [9:0]                req_asid,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic                      rsp_multi,
    output logic [$clog2(TLBNUM)-1:0] rsp_idx,
    output logic [19:0]               rsp_pfn,
    output logic [1:0]                rsp_mat,
    output logic [1:0]                rsp_plv,
    output logic                      rsp_d,
    output logic                      rsp_v,
    input  logic                      w_en,
    input  logic [$clog2(TLBNUM)-1:0] w_idx,
    input  tlb_entry_t                w_entry,
    input  logic [$clog2(TLBNUM)-1:0] r_idx,
    output tlb_entry_t                r_entry,
    output logic [$clog2(TLBNUM)-1:0] fill_idx,
    input  logic                      inv_valid,
    input  logic [4:0]                inv_op,
    input  logic [9:0]                inv_asid,
    input  logic [31:0]               inv_va,
    output logic                      busy,
    output logic                      inv_done
);

    localparam int IDXW = $clog2(TLBNUM);

    tlb_entry_t tlb [TLBNUM];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [TLBNUM-1:0] l_hit;
    page_t             l_page        [TLBNUM];
    logic [TLBNUM-1:0] unused_l_vaeq;
    logic [TLBNUM-1:0] unused_l_asideq;
    logic [TLBNUM-1:0] unused_l_odd;

    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
        tlb_match u_match (
            .entry   (tlb[gi]),
            .vpn     (req_vaddr[31:12]),
            .asid    (req_asid),
            .use_g   (1'b1),
            .hit     (l_hit[gi]),
            .va_eq   (unused_l_vaeq[gi]),
            .asid_eq (unused_l_asideq[gi]),
            .odd     (unused_l_odd[gi]),
            .page    (l_page[gi])
        );
    end

    logic            hit_any;
    logic            hit_multi;
    logic [IDXW-1:0] sel_idx;
    page_t           sel_page;

    // Lowest index wins; any further hit flags a multi-hit
    always_comb begin
        hit_any   = 1'b0;
        hit_multi = 1'b0;
        sel_idx   = '0;
        sel_page  = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (l_hit[i]) begin
                if (hit_any) begin
                    hit_multi = 1'b1;
                end else begin
                    sel_idx  = IDXW'(i);
                    sel_page = l_page[i];
                end
                hit_any = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // INVTLB sweep controller
    // ------------------------------------------------------------------
    sweep_state_e    state;
    sweep_state_e    state_nx;
    logic [IDXW-1:0] sw_idx;
    invtlb_op_e      op_q;
    logic [9:0]      asid_q;
    logic [19:0]     vpn_q;
    logic            start;
    logic            last;

    assign start = (state == ST_IDLE) & inv_valid & (inv_op <= INV_OP_MAX);
    assign last  = (sw_idx == IDXW'(TLBNUM - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SWEEP;
            ST_SWEEP: if (last)  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_SWEEP);
        inv_done  = (state == ST_SWEEP) & last;
        req_ready = (state == ST_IDLE) & ~inv_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_idx <= '0;
            op_q   <= INV_ALL;
            asid_q <= '0;
            vpn_q  <= '0;
        end else if (start) begin
            sw_idx <= '0;
            op_q   <= invtlb_op_e'(inv_op);
            asid_q <= inv_asid;
            vpn_q  <= inv_va[31:12];
        end else if (busy) begin
            sw_idx <= sw_idx + 1'b1;
        end
    end

    logic unused_va_lo;
    assign unused_va_lo = ^inv_va[11:0];

    tlb_entry_t sw_entry;
    logic       sw_hit;
    logic       sw_vaeq;
    logic       sw_asideq;
    logic       unused_sw_odd;
    page_t      unused_sw_page;
    logic       sw_clr;

    assign sw_entry = tlb[sw_idx];

    tlb_match u_sweep_match (
        .entry   (sw_entry),
        .vpn     (vpn_q),
        .asid    (asid_q),
        .use_g   (1'b1),
        .hit     (sw_hit),
        .va_eq   (sw_vaeq),
        .asid_eq (sw_asideq),
        .odd     (unused_sw_odd),
        .page    (unused_sw_page)
    );

    always_comb begin
        sw_clr = 1'b0;
        case (op_q)
            INV_ALL, INV_ALL_1: sw_clr = 1'b1;
            INV_GLOBAL:         sw_clr = sw_entry.g;
            INV_NONGLOBAL:      sw_clr = ~sw_entry.g;
            INV_NG_ASID:        sw_clr = ~sw_entry.g & sw_asideq;
            INV_NG_ASID_VA:     sw_clr = ~sw_entry.g & sw_asideq & sw_vaeq;
            INV_ASID_VA:        sw_clr = sw_hit;
            default:            sw_clr = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Entry array: sweep owns the array while busy, writes are dropped
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                tlb[i] <= '0;
            end
        end else if (busy) begin
            if (sw_clr) begin
                tlb[sw_idx].e <= 1'b0;
            end
        end else if (w_en) begin
            tlb[w_idx] <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic accept;
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_multi <= 1'b0;
            rsp_idx   <= '0;
            rsp_pfn   <= '0;
            rsp_mat   <= '0;
            rsp_plv   <= '0;
            rsp_d     <= 1'b0;
            rsp_v     <= 1'b0;
            r_entry   <= '0;
            fill_idx  <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_hit   <= accept & hit_any;
            rsp_multi <= accept & hit_multi;
            rsp_idx   <= accept ? sel_idx       : '0;
            rsp_pfn   <= accept ? sel_page.ppn  : '0;
            rsp_mat   <= accept ? sel_page.mat  : '0;
            rsp_plv   <= accept ? sel_page.plv  : '0;
            rsp_d     <= accept & sel_page.d;
            rsp_v     <= accept & sel_page.v;
            r_entry   <= tlb[r_idx];
            fill_idx  <= fill_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlb_lookup_unit.sv
module tb_tlb_lookup_unit;
    import tlb_pkg::*;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_vaddr = '0;
    logic [9:0]    req_asid = '0;
    logic          rsp_valid, rsp_hit, rsp_multi;
    logic [IW-1:0] rsp_idx;
    logic [19:0]   rsp_pfn;
    logic [1:0]    rsp_mat, rsp_plv;
    logic          rsp_d, rsp_v;
    logic          w_en = 1'b0;
    logic [IW-1:0] w_idx = '0;
    tlb_entry_t    w_entry = '0;
    logic [IW-1:0] r_idx = '0;
    tlb_entry_t    r_entry;
    logic [IW-1:0] fill_idx;
    logic          inv_valid = 1'b0;
    logic [4:0]    inv_op = '0;
    logic [9:0]    inv_asid = '0;
    logic [31:0]   inv_va = '0;
    logic          busy, inv_done;

    tlb_lookup_unit #(.TLBNUM(N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_asid(req_asid),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_multi(rsp_multi), .rsp_idx(rsp_idx),
        .rsp_pfn(rsp_pfn), .rsp_mat(rsp_mat), .rsp_plv(rsp_plv), .rsp_d(rsp_d), .rsp_v(rsp_v),
        .w_en(w_en), .w_idx(w_idx), .w_entry(w_entry),
        .r_idx(r_idx), .r_entry(r_entry), .fill_idx(fill_idx),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .busy(busy), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    tlb_entry_t m_tlb   [N];
    bit         m_known [N];
    int         m_fill = 0;
    bit         m_act = 0;
    int         m_k = 0;
    logic [4:0] m_op = '0;
    logic [9:0] m_asid = '0;
    logic [31:0] m_va = '0;

    function automatic bit va_match(input tlb_entry_t t, input logic [31:0] va);
        if (t.ps4m) return (t.vppn >> 9) == 19'(va >> 22);
        return t.vppn == 19'(va >> 13);
    endfunction

    function automatic void mlook(input logic [31:0] va, input logic [9:0] asid,
                                  output int nh, output int first, output page_t pg);
        tlb_entry_t t;
        bit odd;
        nh = 0; first = 0; pg = '0;
        for (int i = 0; i < N; i++) begin
            t = m_tlb[i];
            if (t.e && (t.g || t.asid == asid) && va_match(t, va)) begin
                if (nh == 0) begin
                    first = i;
                    odd = t.ps4m ? va[21] : va[12];
                    pg = odd ? t.p1 : t.p0;
                    if (t.ps4m) pg.ppn = (pg.ppn & 20'hFFC00) | 20'((va >> 12) & 32'h3FF);
                end
                nh++;
            end
        end
    endfunction

    function automatic bit mpred(input tlb_entry_t t);
        bit ae;
        bit ve;
        ae = (t.asid == m_asid);
        ve = va_match(t, m_va);
        case (m_op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return t.g;
            5'd3:       return !t.g;
            5'd4:       return !t.g && ae;
            5'd5:       return !t.g && ae && ve;
            5'd6:       return (t.g || ae) && ve;
            default:    return 1'b0;
        endcase
    endfunction

    bit         e_valid;
    int         e_nh, e_idx;
    page_t      e_pg;
    tlb_entry_t e_r;
    bit         e_rknown;
    bit         e_rst;

    always @(posedge clk) begin
        e_rst = !resetn;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_tlb[i].e = 1'b0;
                m_known[i] = 1'b0;
            end
            m_fill = 0; m_act = 0; m_k = 0;
            e_valid = 0; e_nh = 0; e_idx = 0; e_pg = '0; e_r = '0; e_rknown = 1;
        end else begin
            e_valid = req_valid && !m_act && !inv_valid;
            if (e_valid) mlook(req_vaddr, req_asid, e_nh, e_idx, e_pg);
            e_r = m_tlb[r_idx];
            e_rknown = m_known[r_idx];
            m_fill = (m_fill + 1) % N;
            if (m_act) begin
                if (mpred(m_tlb[m_k])) m_tlb[m_k].e = 1'b0;
                m_k++;
                if (m_k == N) m_act = 0;
            end else begin
                if (w_en) begin
                    m_tlb[w_idx] = w_entry;
                    m_known[w_idx] = 1'b1;
                end
                if (inv_valid && inv_op <= 5'd6) begin
                    m_act = 1; m_k = 0;
                    m_op = inv_op; m_asid = inv_asid; m_va = inv_va;
                end
            end
        end
        #2;
        chk("rsp_valid", rsp_valid, e_valid);
        if (e_valid) begin
            chk("rsp_hit",   rsp_hit,   e_nh > 0);
            chk("rsp_multi", rsp_multi, e_nh > 1);
            if (e_nh > 0) chk("rsp_idx", rsp_idx, e_idx);
            chk("rsp_pfn", rsp_pfn, e_pg.ppn);
            chk("rsp_mat", rsp_mat, e_pg.mat);
            chk("rsp_plv", rsp_plv, e_pg.plv);
            chk("rsp_d",   rsp_d,   e_pg.d);
            chk("rsp_v",   rsp_v,   e_pg.v);
        end else if (e_rst) begin
            chk("rst_rsp", {rsp_hit, rsp_multi, rsp_idx, rsp_pfn, rsp_mat, rsp_plv, rsp_d, rsp_v}, '0);
        end
        if (e_rknown) chk("r_entry", r_entry, e_r);
        else          chk("r_entry_e", r_entry.e, e_r.e);
        chk("fill_idx",  fill_idx,  m_fill);
        chk("busy",      busy,      m_act);
        chk("inv_done",  inv_done,  m_act && m_k == N - 1);
        chk("req_ready", req_ready, !m_act && !inv_valid);
    end

    always @(posedge clk)
        if (resetn) assert (!(w_en && busy)) else $error("protocol error: write while busy");

    // ---------------- stimulus ----------------
    logic        l_hit, l_multi;
    logic [IW-1:0] l_idx;
    logic [19:0] l_pfn;

    function automatic tlb_entry_t mk(input logic [18:0] vppn, input bit ps4m, input bit g,
                                      input logic [9:0] asid, input logic [19:0] ppn0,
                                      input logic [19:0] ppn1);
        tlb_entry_t t;
        t = '0;
        t.vppn = vppn; t.ps4m = ps4m; t.g = g; t.asid = asid; t.e = 1'b1;
        t.p0.ppn = ppn0; t.p0.v = 1'b1; t.p0.mat = 2'd1;
        t.p1.ppn = ppn1; t.p1.v = 1'b1; t.p1.plv = 2'd3; t.p1.d = 1'b1;
        return t;
    endfunction

    task automatic wr(input int idx, input tlb_entry_t e);
        w_en = 1'b1; w_idx = IW'(idx); w_entry = e;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic look(input logic [31:0] va, input logic [9:0] asid);
        req_valid = 1'b1; req_vaddr = va; req_asid = asid;
        @(posedge clk); #2;
        l_hit = rsp_hit; l_multi = rsp_multi; l_idx = rsp_idx; l_pfn = rsp_pfn;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_va();
        return 32'(($urandom_range(0, 1) << 21) | ($urandom_range(0, 7) << 13) | $urandom_range(0, 8191));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int done_at;
        tlb_entry_t t;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fill", fill_idx, 0);
        resetn = 1'b1;

        // basic 4KB hit, even page
        wr(3, mk(19'h00040, 1'b0, 1'b0, 10'd5, 20'h12345, 20'h0));
        look(32'h0008_0123, 10'd5);
        chk("lit_hit", l_hit, 1'b1);
        chk("lit_idx", l_idx, 3);
        chk("lit_pfn", l_pfn, 20'h12345);

        // ASID mismatch on non-global, then global
        look(32'h0008_0123, 10'd6);
        chk("lit_asid_miss", l_hit, 1'b0);
        wr(3, mk(19'h00040, 1'b0, 1'b1, 10'd5, 20'h12345, 20'h0));
        look(32'h0008_0123, 10'd6);
        chk("lit_global_hit", l_hit, 1'b1);

        // 4MB page, odd half, merged PFN {ppn1[19:10], va[21:12]}
        wr(4, mk(19'h00200, 1'b1, 1'b0, 10'd7, 20'h0, 20'h40000));
        look(32'h0061_2000, 10'd7);
        chk("lit_4m_idx", l_idx, 4);
        chk("lit_4m_pfn", l_pfn, 20'h40212);

        // duplicate entries -> multi-hit, lowest index
        wr(2, mk(19'h00100, 1'b0, 1'b0, 10'd9, 20'hAAAAA, 20'h0));
        wr(7, mk(19'h00100, 1'b0, 1'b0, 10'd9, 20'hBBBBB, 20'h0));
        look(32'h0020_0000, 10'd9);
        chk("lit_multi", l_multi, 1'b1);
        chk("lit_multi_idx", l_idx, 2);
        chk("lit_multi_pfn", l_pfn, 20'hAAAAA);

        // INVTLB op4 asid 5
        wr(5, mk(19'h00055, 1'b0, 1'b0, 10'd5, 20'h00555, 20'h0));
        inv_valid = 1'b1; inv_op = 5'd4; inv_asid = 10'd5; inv_va = '0;
        @(negedge clk);
        inv_valid = 1'b0;
        nb = 0; done_at = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            nb++;
            chk("lit_sweep_ready", req_ready, 1'b0);
            if (inv_done) done_at = nb;
            @(negedge clk);
        end
        chk("lit_sweep_len", nb, N);
        chk("lit_sweep_done", done_at, N);
        look(32'h0055 << 13, 10'd5);
        chk("lit_inv_cleared", l_hit, 1'b0);
        look(32'h0008_0123, 10'd5);
        chk("lit_inv_global_kept", l_hit, 1'b1);

        // back-to-back lookups with same-cycle write, plus TLBRD of that index
        req_valid = 1'b1; req_vaddr = 32'h0008_0123; req_asid = 10'd5; r_idx = 4'd3;
        w_en = 1'b1; w_idx = 4'd3; w_entry = mk(19'h00040, 1'b0, 1'b1, 10'd5, 20'h54321, 20'h0);
        @(posedge clk); #2;
        chk("lit_b2b_old", rsp_pfn, 20'h12345);
        chk("lit_rd_old", r_entry.p0.ppn, 20'h12345);
        @(negedge clk);
        w_en = 1'b0;
        @(posedge clk); #2;
        chk("lit_b2b_new", rsp_pfn, 20'h54321);
        @(negedge clk);
        req_valid = 1'b0;

        // invalid op: no sweep
        inv_valid = 1'b1; inv_op = 5'd7;
        @(negedge clk);
        inv_valid = 1'b0;
        chk("lit_badop_busy", busy, 1'b0);

        // reset mid-sweep
        inv_valid = 1'b1; inv_op = 5'd0;
        @(negedge clk);
        inv_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("lit_rst_sweep_busy", busy, 1'b0);
        chk("lit_rst_sweep_done", inv_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // randomized phase
        for (int c = 0; c < 1500; c++) begin
            req_valid = 1'b0; w_en = 1'b0; inv_valid = 1'b0;
            r_idx = IW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 3) != 0) begin
                req_valid = 1'b1;
                req_vaddr = rnd_va();
                req_asid  = 10'($urandom_range(1, 3));
            end
            if (!busy && $urandom_range(0, 3) == 0) begin
                t = mk(19'(($urandom_range(0, 1) << 8) | $urandom_range(0, 7)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       10'($urandom_range(1, 3)), 20'($urandom), 20'($urandom));
                t.e  = ($urandom_range(0, 7) != 0);
                t.p0 = page_t'(26'($urandom));
                t.p1 = page_t'(26'($urandom));
                w_en = 1'b1; w_idx = IW'($urandom_range(0, N - 1)); w_entry = t;
            end
            if (!busy && $urandom_range(0, 49) == 0) begin
                inv_valid = 1'b1;
                inv_op    = 5'($urandom_range(0, 7));
                inv_asid  = 10'($urandom_range(1, 3));
                inv_va    = rnd_va();
            end
            @(negedge clk);
        end
        req_valid = 1'b0; w_en = 1'b0; inv_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
